// File: rtl/life_pkg.sv
// Shared types and helpers for the 4x4 Game of Life engine.
package life_pkg;

  localparam int BOARD_DIM = 4;
  localparam int CELLS     = 16;

  typedef logic [3:0] cell_idx_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPUTE    = 2'd1,
    WAIT_FRAME = 2'd2
  } state_t;

  // Linear board index of column x, row y: y*4+x.
  function automatic cell_idx_t cell_idx(input logic [1:0] x, input logic [1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Combinational Game of Life rule for one cell of the 4x4 board.
// Counts the eight neighbours of cell idx_i and applies the birth/survival rule.
// Build option LIFE_TORUS_EN: neighbour coordinates wrap modulo 4 (toroidal
// board); without it, neighbours outside the board count as dead.
module life_cell_rule
  import life_pkg::*;
(
  input  logic [15:0] board_i,
  input  logic [3:0]  idx_i,
  output logic        next_o,
  output logic [3:0]  count_o
);

  logic [1:0] x;
  logic [1:0] y;
  logic [3:0] cnt;

  assign x = idx_i[1:0];
  assign y = idx_i[3:2];

  // Sum the live neighbours around (x, y).
  always_comb begin
    int nx;
    int ny;
    cnt = 4'd0;
    nx  = 0;
    ny  = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (!(dx == 0 && dy == 0)) begin
          nx = int'(x) + dx;
          ny = int'(y) + dy;
`ifdef LIFE_TORUS_EN
          // Truncating to two bits folds -1 to 3 and 4 to 0.
          cnt = cnt + {3'b000, board_i[cell_idx(2'(nx), 2'(ny))]};
`else
          if (nx >= 0 && nx < BOARD_DIM && ny >= 0 && ny < BOARD_DIM)
            cnt = cnt + {3'b000, board_i[cell_idx(2'(nx), 2'(ny))]};
`endif
        end
      end
    end
  end

  // Birth on exactly three, survival on two or three.
  always_comb begin
    next_o  = (cnt == 4'd3) || (board_i[idx_i] && (cnt == 4'd2));
    count_o = cnt;
  end

endmodule

// File: rtl/life_4x4_stepper.sv
// Generation engine for the 4x4 Game of Life board.
// Computes the next generation one cell per clock from the frozen current
// board, then commits it on a frame tick so the display never tears.
// Build option LIFE_TORUS_EN (handled in life_cell_rule) selects a toroidal
// board; ports and timing are identical either way.
module life_4x4_stepper
  import life_pkg::*;
#(
  parameter logic [15:0] INIT_BOARD = 16'h0000,
  parameter int          FRAME_DIV  = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        step,
  input  logic        run,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] alive,
  output logic        busy,
  output logic        stable,
  output logic [15:0] gen_count
);

  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  state_t      state_q, state_d;
  cell_idx_t   idx_q, idx_d;
  logic [15:0] next_q, next_d;
  logic [7:0]  div_q, div_d;
  logic        gen_req_q, gen_req_d;
  logic [15:0] alive_q, alive_d;
  logic [15:0] gen_count_q, gen_count_d;
  logic        stable_q, stable_d;
  logic        busy_q;

  logic        start_gen;
  logic        compute_en;
  logic        commit;
  logic        div_wrap;
  logic        rule_next;
  logic [3:0]  rule_count;
  logic        cell_next;

  life_cell_rule u_rule (
    .board_i (alive_q),
    .idx_i   (idx_q),
    .next_o  (rule_next),
    .count_o (rule_count)
  );

  // An isolated cell can never be alive next generation.
  assign cell_next = rule_next && (rule_count != 4'd0);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; load overrides everything and abandons any generation.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       if (step || gen_req_q) state_d = COMPUTE;
        COMPUTE:    if (idx_q == 4'd15)    state_d = WAIT_FRAME;
        WAIT_FRAME: if (frame_tick)        state_d = IDLE;
        default:                           state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: datapath strobes decoded from the current state.
  always_comb begin
    start_gen  = (state_q == IDLE) && (step || gen_req_q) && !load;
    compute_en = (state_q == COMPUTE) && !load;
    commit     = (state_q == WAIT_FRAME) && frame_tick && !load;
  end

  // Datapath next-state: cell walk, frame divider, request latch and commit.
  always_comb begin
    div_wrap = frame_tick && (div_q == DIV_LAST);
    div_d    = div_q;
    if (frame_tick) div_d = div_wrap ? 8'd0 : div_q + 8'd1;

    gen_req_d = gen_req_q;
    if (start_gen)      gen_req_d = 1'b0;
    if (div_wrap && run) gen_req_d = 1'b1;
    if (load)           gen_req_d = 1'b0;

    idx_d  = idx_q;
    next_d = next_q;
    if (compute_en) begin
      next_d[idx_q] = cell_next;
      idx_d         = idx_q + 4'd1;
    end
    if (start_gen || load) idx_d = 4'd0;

    alive_d     = alive_q;
    gen_count_d = gen_count_q;
    stable_d    = stable_q;
    if (load) begin
      alive_d     = seed;
      gen_count_d = 16'd0;
      stable_d    = 1'b0;
    end else if (commit) begin
      alive_d     = next_q;
      gen_count_d = gen_count_q + 16'd1;
      stable_d    = (next_q == alive_q);
    end
  end

  // Datapath registers and the registered busy decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= 4'd0;
      next_q      <= 16'd0;
      div_q       <= 8'd0;
      gen_req_q   <= 1'b0;
      alive_q     <= INIT_BOARD;
      gen_count_q <= 16'd0;
      stable_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      next_q      <= next_d;
      div_q       <= div_d;
      gen_req_q   <= gen_req_d;
      alive_q     <= alive_d;
      gen_count_q <= gen_count_d;
      stable_q    <= stable_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign alive     = alive_q;
  assign busy      = busy_q;
  assign stable    = stable_q;
  assign gen_count = gen_count_q;

endmodule
